rob_alloc: RTL and testbench
============================

# rob_alloc

Reorder-buffer slot allocator and flush sequencer for the out-of-order core. Hands ROB indices to the decode/issue stage in program order, mirrors the ROB head pointer from commit pulses, and tracks occupancy to throttle issue when the ROB is full. On a committed exception it captures the faulting PC/address, then drives the ROB `clear` for one cycle and issues a fetch redirect.

## Interface
- `ROB_SLOTS`, 16: number of ROB entries; must be a power of two ≥ 2.
- `ROB_IDX_BITS`, 4: log2(`ROB_SLOTS`).
- `ARCH_BITS`, 32: PC/address width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `allocReq`  in  1  decode requests one ROB slot this cycle.
- `allocReady`  out  1  slot available; allocation happens on `allocReq && allocReady`.
- `allocIdx`  out  `ROB_IDX_BITS`  index granted (current tail).
- `commit`  in  1  ROB retired its head entry this cycle.
- `except`, `excPc`, `excAddr`  in  1/`ARCH_BITS`/`ARCH_BITS`  ROB head exception and its PC/address.
- `clear`  out  1  one-cycle flush to ROB and pipeline.
- `redirect`  out  1  one-cycle fetch redirect, coincident with `clear`.
- `redirectPc`, `redirectAddr`  out  `ARCH_BITS`  captured exception PC/address, stable from the `clear` cycle until the next exception.
- `count`  out  `ROB_IDX_BITS+1`  current occupancy, 0..`ROB_SLOTS`.
- `empty`  out  1  `count == 0`.

## Operation
- State register: `tail`, `head` (`ROB_IDX_BITS` each), `count`, FSM {RUN, FLUSH}.
- Reset (async, `rst` low): `tail=head=0`, `count=0`, state RUN, `clear=redirect=0`, `redirectPc=redirectAddr=0`, `empty=1`. `allocReady` forced 0 while `rst` low.
- RUN:
  - `allocReady = (count != ROB_SLOTS)`; `allocIdx = tail`. Neither depends on same-cycle `commit` (no full bypass).
  - Accepted allocation: `tail <= tail+1` (wraps modulo `ROB_SLOTS`), `count` +1.
  - `commit` with `count != 0`: `head <= head+1` (wraps), `count` −1. `commit` with `count == 0` is ignored.
  - Allocation and commit in the same cycle: `count` unchanged, both pointers advance.
  - `except=1`: capture `excPc`/`excAddr` into `redirectPc`/`redirectAddr`, go to FLUSH. Pointer and count updates from that cycle's alloc/commit still occur but are discarded by the flush.
- FLUSH (exactly one cycle):
  - `clear=1`, `redirect=1`, `allocReady=0`. Inputs `allocReq`, `commit`, `except` are ignored.
  - At the closing edge: `tail=head=0`, `count=0`, state RUN.
- Invariant: `(tail − head) mod ROB_SLOTS == count mod ROB_SLOTS`; `head` always equals the ROB's internal head index.

## Timing
- `allocIdx`/`allocReady` valid combinationally from registered state; index usable in the grant cycle.
- `count`/`empty` reflect an allocation or commit one cycle after it.
- `except` in cycle N → `clear`/`redirect` high in cycle N+1 only → `allocReady=1`, `allocIdx=0` in cycle N+2.
- Full→ready: commit in cycle N with `count==ROB_SLOTS` → `allocReady=1` in N+1.
- Reset asserted mid-FLUSH: `clear`/`redirect` drop immediately (asynchronous).

## Configuration
- `ROB_ALLOC_STALL_CNT_EN`: when defined, adds output `stallCycles` (32 bits, reset 0) counting cycles with `allocReq=1 && allocReady=0` in RUN, saturating at 0xFFFFFFFF, not cleared by flush. When undefined, the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset, then 16 back-to-back `allocReq` → `allocIdx` 0..15, `allocReady` drops in cycle 17, `count=16`.
- Full ROB, `allocReq` held, one `commit` → `allocReady=1` next cycle, `allocIdx=0` (wrap), `head=1`.
- `count=5`, simultaneous `allocReq` and `commit` for 3 cycles → `count` stays 5, `tail` and `head` each advance by 3.
- `except=1` with `excPc=0x400`, `excAddr=0x1234` → next cycle `clear=redirect=1`, `redirectPc=0x400`, `redirectAddr=0x1234`; following cycle `count=0`, `allocIdx=0`, `allocReady=1`.
- `commit` with `count=0` → `head`, `count` unchanged; `rst` pulsed low during FLUSH → `clear` drops same cycle, all outputs at reset values.
- With `ROB_ALLOC_STALL_CNT_EN`: fill ROB, hold `allocReq` 7 cycles while full → `stallCycles=7`; flush → still 7.

Source files
------------

// File: rtl/rob_alloc_if.sv
// Decode/ROB handshake bundle for rob_alloc: allocation, commit, exception and flush signals.
// stallCycles exists only when ROB_ALLOC_STALL_CNT_EN is defined.
interface rob_alloc_if #(
  parameter int unsigned ROB_IDX_BITS = 4,
  parameter int unsigned ARCH_BITS    = 32
);
  logic                    allocReq;
  logic                    allocReady;
  logic [ROB_IDX_BITS-1:0] allocIdx;
  logic                    commit;
  logic                    except;
  logic [ARCH_BITS-1:0]    excPc;
  logic [ARCH_BITS-1:0]    excAddr;
  logic                    clear;
  logic                    redirect;
  logic [ARCH_BITS-1:0]    redirectPc;
  logic [ARCH_BITS-1:0]    redirectAddr;
  logic [ROB_IDX_BITS:0]   count;
  logic                    empty;
`ifdef ROB_ALLOC_STALL_CNT_EN
  logic [31:0]             stallCycles;
`endif

  modport master (
`ifdef ROB_ALLOC_STALL_CNT_EN
    input  stallCycles,
`endif
    output allocReq, commit, except, excPc, excAddr,
    input  allocReady, allocIdx, clear, redirect, redirectPc, redirectAddr, count, empty
  );

  modport slave (
`ifdef ROB_ALLOC_STALL_CNT_EN
    output stallCycles,
`endif
    input  allocReq, commit, except, excPc, excAddr,
    output allocReady, allocIdx, clear, redirect, redirectPc, redirectAddr, count, empty
  );
endinterface

// File: rtl/rob_alloc.sv
// ROB slot allocator and one-cycle exception flush sequencer.
// Optional saturating stall counter enabled by defining ROB_ALLOC_STALL_CNT_EN.
module rob_alloc #(
  parameter int unsigned ROB_SLOTS    = 16,
  parameter int unsigned ROB_IDX_BITS = 4,
  parameter int unsigned ARCH_BITS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  rob_alloc_if.slave  bus
);
  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [ROB_IDX_BITS:0]   FULL    = (ROB_IDX_BITS+1)'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS-1:0] IDX_ONE = ROB_IDX_BITS'(1);
  localparam logic [ROB_IDX_BITS:0]   CNT_ONE = (ROB_IDX_BITS+1)'(1);

  state_t                  state, state_nxt;
  logic [ROB_IDX_BITS-1:0] tail, tail_nxt, head, head_nxt;
  logic [ROB_IDX_BITS:0]   count, count_nxt;
  logic [ARCH_BITS-1:0]    pc_q, pc_nxt, addr_q, addr_nxt;
  logic                    ready, do_alloc, do_commit, clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      tail   <= '0;
      head   <= '0;
      count  <= '0;
      pc_q   <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      tail   <= tail_nxt;
      head   <= head_nxt;
      count  <= count_nxt;
      pc_q   <= pc_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Alloc/commit still move the pointers in the exception cycle; FLUSH zeroes them next.
  always_comb begin
    state_nxt = state;
    tail_nxt  = tail;
    head_nxt  = head;
    count_nxt = count;
    pc_nxt    = pc_q;
    addr_nxt  = addr_q;
    ready     = 1'b0;
    clear     = 1'b0;
    do_alloc  = 1'b0;
    do_commit = 1'b0;
    case (state)
      RUN: begin
        ready     = rst && (count != FULL);
        do_alloc  = bus.allocReq && ready;
        do_commit = bus.commit && (count != '0);
        if (do_alloc)  tail_nxt = tail + IDX_ONE;
        if (do_commit) head_nxt = head + IDX_ONE;
        if (do_alloc && !do_commit)      count_nxt = count + CNT_ONE;
        else if (!do_alloc && do_commit) count_nxt = count - CNT_ONE;
        if (bus.except) begin
          pc_nxt    = bus.excPc;
          addr_nxt  = bus.excAddr;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        clear     = 1'b1;
        tail_nxt  = '0;
        head_nxt  = '0;
        count_nxt = '0;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.allocReady   = ready;
  assign bus.allocIdx     = tail;
  assign bus.clear        = clear;
  assign bus.redirect     = clear;
  assign bus.redirectPc   = pc_q;
  assign bus.redirectAddr = addr_q;
  assign bus.count        = count;
  assign bus.empty        = (count == '0);

`ifdef ROB_ALLOC_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else if (state == RUN && bus.allocReq && !ready && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign bus.stallCycles = stall_q;
`endif
endmodule

// File: tb/tb_rob_alloc.sv
// Self-checking bench for rob_alloc: directed scenarios then random traffic against an occupancy model.
module tb_rob_alloc;
  localparam int SLOTS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rob_alloc_if #(.ROB_IDX_BITS(4), .ARCH_BITS(32)) bus ();

  rob_alloc #(.ROB_SLOTS(16), .ROB_IDX_BITS(4), .ARCH_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: occupancy as head + count; tail is implied by the ring invariant.
  int          m_head, m_count;
  bit          m_flush;
  logic [31:0] m_pc, m_addr;
  longint      m_stall;

  task automatic model_reset();
    m_head = 0; m_count = 0; m_flush = 0; m_pc = '0; m_addr = '0; m_stall = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = !m_flush && (m_count != SLOTS);
    chk("allocReady", 64'(bus.allocReady), 64'(rdy));
    chk("allocIdx", 64'(bus.allocIdx), 64'((m_head + m_count) % SLOTS));
    chk("count", 64'(bus.count), 64'(m_count));
    chk("empty", 64'(bus.empty), 64'(m_count == 0));
    chk("clear", 64'(bus.clear), 64'(m_flush));
    chk("redirect", 64'(bus.redirect), 64'(m_flush));
    chk("redirectPc", 64'(bus.redirectPc), 64'(m_pc));
    chk("redirectAddr", 64'(bus.redirectAddr), 64'(m_addr));
`ifdef ROB_ALLOC_STALL_CNT_EN
    chk("stallCycles", 64'(bus.stallCycles), 64'(m_stall));
`endif
  endtask

  // Check current outputs, advance the model by one clock, then move 1 ns past the edge.
  task automatic step();
    bit rdy, a, c;
    check_outputs();
    rdy = !m_flush && (m_count != SLOTS);
    if (m_flush) begin
      m_head = 0; m_count = 0; m_flush = 0;
    end else begin
      a = bus.allocReq && rdy;
      c = bus.commit && (m_count != 0);
      if (bus.allocReq && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
      m_head  = (m_head + int'(c)) % SLOTS;
      m_count = m_count + int'(a) - int'(c);
      if (bus.except) begin
        m_flush = 1; m_pc = bus.excPc; m_addr = bus.excAddr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit req, input bit cmt, input bit exc);
    bus.allocReq = req; bus.commit = cmt; bus.except = exc;
  endtask

  initial begin
    int h0;
    bus.allocReq = 0; bus.commit = 0; bus.except = 0;
    bus.excPc = '0; bus.excAddr = '0;
    model_reset();

    // Reset values, including allocReady held low while reset is asserted
    #3;
    chk("rst_allocReady", 64'(bus.allocReady), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_clear", 64'(bus.clear), 64'd0);
    chk("rst_redirectPc", 64'(bus.redirectPc), 64'd0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // Fill: indices 0..15, then not ready with count 16
    for (int i = 0; i < SLOTS; i++) begin
      drive(1, 0, 0);
      chk("fill_idx", 64'(bus.allocIdx), 64'(i));
      step();
    end
    drive(0, 0, 0);
    chk("full_ready", 64'(bus.allocReady), 64'd0);
    chk("full_count", 64'(bus.count), 64'd16);

    // Full with request held plus one commit: ready next cycle, index wraps to 0
    drive(1, 1, 0);
    step();
    chk("wrap_ready", 64'(bus.allocReady), 64'd1);
    chk("wrap_idx", 64'(bus.allocIdx), 64'd0);
    chk("wrap_head", 64'(dut.head), 64'd1);
    drive(0, 0, 0);
    step();

    // Flush to a clean slate, then reach count 5
    bus.excPc = 32'h400; bus.excAddr = 32'h1234;
    drive(1, 1, 1);
    step();
    drive(0, 0, 0);
    chk("exc_clear", 64'(bus.clear), 64'd1);
    chk("exc_redirect", 64'(bus.redirect), 64'd1);
    chk("exc_pc", 64'(bus.redirectPc), 64'h400);
    chk("exc_addr", 64'(bus.redirectAddr), 64'h1234);
    chk("exc_ready_low", 64'(bus.allocReady), 64'd0);
    drive(1, 1, 1);
    bus.excPc = 32'hDEAD; bus.excAddr = 32'hBEEF;
    step();
    drive(0, 0, 0);
    chk("post_flush_count", 64'(bus.count), 64'd0);
    chk("post_flush_idx", 64'(bus.allocIdx), 64'd0);
    chk("post_flush_ready", 64'(bus.allocReady), 64'd1);
    chk("post_flush_pc_held", 64'(bus.redirectPc), 64'h400);

    // Commit on empty is ignored
    drive(0, 1, 0);
    step();
    chk("empty_commit_head", 64'(dut.head), 64'd0);
    chk("empty_commit_count", 64'(bus.count), 64'd0);

    for (int i = 0; i < 5; i++) begin drive(1, 0, 0); step(); end
    h0 = m_head;
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0); step(); end
    drive(0, 0, 0);
    chk("steady_count", 64'(bus.count), 64'd5);
    chk("steady_tail", 64'(bus.allocIdx), 64'd8);
    chk("steady_head", 64'(dut.head), 64'(h0 + 3));

    // Fill up and stall for 7 cycles, then flush
    while (m_count != SLOTS) begin drive(1, 0, 0); step(); end
    for (int i = 0; i < 7; i++) begin drive(1, 0, 0); step(); end
    drive(0, 0, 1);
    step();
    drive(0, 0, 0);
    step();
    check_outputs();

    // Reset pulse during FLUSH drops clear/redirect immediately
    drive(0, 0, 1);
    step();
    drive(0, 0, 0);
    chk("mid_flush_clear", 64'(bus.clear), 64'd1);
    rst = 0;
    #1;
    model_reset();
    chk("arst_clear", 64'(bus.clear), 64'd0);
    chk("arst_redirect", 64'(bus.redirect), 64'd0);
    chk("arst_pc", 64'(bus.redirectPc), 64'd0);
    chk("arst_ready", 64'(bus.allocReady), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.allocReq = ($urandom_range(0, 3) != 0);
      bus.commit   = ($urandom_range(0, 2) == 0);
      bus.except   = ($urandom_range(0, 24) == 0);
      bus.excPc    = $urandom;
      bus.excAddr  = $urandom;
      step();
    end
    drive(0, 0, 0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
